// File: rtl/cs_pkg.sv
// Shared types and constants for the three-input compare-sort cell and its
// two-input compare-exchange building block.
package cs_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'd0;
  localparam sel_t SEL_B = 2'd1;
  localparam sel_t SEL_C = 2'd2;

  localparam int CS_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/cs_cmp2.sv
// Combinational two-input compare-exchange. Operand x is the lower-index one,
// so it takes the hi slot on ties to keep the overall sort stable.
module cs_cmp2
  import cs_pkg::*;
#(
  parameter int WIDTH = CS_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  sel_t             xSel,
  input  logic [WIDTH-1:0] y,
  input  sel_t             ySel,
  output logic [WIDTH-1:0] hi,
  output sel_t             hiSel,
  output logic [WIDTH-1:0] lo,
  output sel_t             loSel
);

  logic xWins;

  assign xWins = (x >= y);
  assign hi    = xWins ? x : y;
  assign hiSel = xWins ? xSel : ySel;
  assign lo    = xWins ? y : x;
  assign loSel = xWins ? ySel : xSel;

endmodule

// File: rtl/cs.sv
// Registered three-input stable compare-sort cell (max/mid/min plus origin tags).
// Define CS_PIPE_EN to register the (a,b) compare-exchange result: latency 2 instead of 1.
module cs
  import cs_pkg::*;
#(
  parameter int WIDTH = CS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  output logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] mid,
  output logic [WIDTH-1:0] min,
  output sel_t             max_sel,
  output sel_t             mid_sel,
  output sel_t             min_sel
);

  logic [WIDTH-1:0] abHi, abLo;
  sel_t             abHiSel, abLoSel;

  cs_cmp2 #(.WIDTH(WIDTH)) uCmpAb (
    .x(a), .xSel(SEL_A), .y(b), .ySel(SEL_B),
    .hi(abHi), .hiSel(abHiSel), .lo(abLo), .loSel(abLoSel)
  );

  logic [WIDTH-1:0] s2Hi, s2Lo, s2C;
  sel_t             s2HiSel, s2LoSel, s2CSel;
  logic             s2Valid;

`ifdef CS_PIPE_EN
  logic [WIDTH-1:0] stgHi_q, stgLo_q, stgC_q;
  sel_t             stgHiSel_q, stgLoSel_q, stgCSel_q;
  logic             stgValid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stgHi_q    <= '0;
      stgLo_q    <= '0;
      stgC_q     <= '0;
      stgHiSel_q <= SEL_A;
      stgLoSel_q <= SEL_B;
      stgCSel_q  <= SEL_C;
      stgValid_q <= 1'b0;
    end else begin
      stgValid_q <= in_valid;
      if (in_valid) begin
        stgHi_q    <= abHi;
        stgLo_q    <= abLo;
        stgC_q     <= c;
        stgHiSel_q <= abHiSel;
        stgLoSel_q <= abLoSel;
        stgCSel_q  <= SEL_C;
      end
    end
  end

  assign s2Hi    = stgHi_q;
  assign s2Lo    = stgLo_q;
  assign s2C     = stgC_q;
  assign s2HiSel = stgHiSel_q;
  assign s2LoSel = stgLoSel_q;
  assign s2CSel  = stgCSel_q;
  assign s2Valid = stgValid_q;
`else
  assign s2Hi    = abHi;
  assign s2Lo    = abLo;
  assign s2C     = c;
  assign s2HiSel = abHiSel;
  assign s2LoSel = abLoSel;
  assign s2CSel  = SEL_C;
  assign s2Valid = in_valid;
`endif

  logic [WIDTH-1:0] max_d, restV;
  sel_t             maxSel_d, restSel;

  cs_cmp2 #(.WIDTH(WIDTH)) uCmpHiC (
    .x(s2Hi), .xSel(s2HiSel), .y(s2C), .ySel(s2CSel),
    .hi(max_d), .hiSel(maxSel_d), .lo(restV), .loSel(restSel)
  );

  // The leftover from the upper exchange is c (index 2) or the former (a,b) winner,
  // which always outranks the (a,b) loser; feed the lower-index operand as x.
  logic             loFirst;
  logic [WIDTH-1:0] lx, ly, mid_d, min_d;
  sel_t             lxSel, lySel, midSel_d, minSel_d;

  assign loFirst = (restSel == SEL_C);
  assign lx      = loFirst ? s2Lo : restV;
  assign lxSel   = loFirst ? s2LoSel : restSel;
  assign ly      = loFirst ? restV : s2Lo;
  assign lySel   = loFirst ? restSel : s2LoSel;

  cs_cmp2 #(.WIDTH(WIDTH)) uCmpLo (
    .x(lx), .xSel(lxSel), .y(ly), .ySel(lySel),
    .hi(mid_d), .hiSel(midSel_d), .lo(min_d), .loSel(minSel_d)
  );

  logic [WIDTH-1:0] max_q, mid_q, min_q;
  sel_t             maxSel_q, midSel_q, minSel_q;
  logic             outValid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q      <= '0;
      mid_q      <= '0;
      min_q      <= '0;
      maxSel_q   <= SEL_A;
      midSel_q   <= SEL_B;
      minSel_q   <= SEL_C;
      outValid_q <= 1'b0;
    end else begin
      outValid_q <= s2Valid;
      if (s2Valid) begin
        max_q    <= max_d;
        mid_q    <= mid_d;
        min_q    <= min_d;
        maxSel_q <= maxSel_d;
        midSel_q <= midSel_d;
        minSel_q <= minSel_d;
      end
    end
  end

  assign out_valid = outValid_q;
  assign max       = max_q;
  assign mid       = mid_q;
  assign min       = min_q;
  assign max_sel   = maxSel_q;
  assign mid_sel   = midSel_q;
  assign min_sel   = minSel_q;

endmodule

// File: tb/tb_cs.sv
// Directed self-checking bench for the cs compare-sort cell; follows CS_PIPE_EN
// for the expected latency.
module tb_cs;

`ifdef CS_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [29:0] RESET_VEC = {8'd0, 8'd0, 8'd0, 2'd0, 2'd1, 2'd2};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a = 8'd0, b = 8'd0, c = 8'd0;
  logic       out_valid;
  logic [7:0] max, mid, min;
  logic [1:0] max_sel, mid_sel, min_sel;
  logic [29:0] obs;

  int compared = 0;
  int mismatched = 0;

  cs #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .c(c),
    .out_valid(out_valid), .max(max), .mid(mid), .min(min),
    .max_sel(max_sel), .mid_sel(mid_sel), .min_sel(min_sel)
  );

  always #5 clk = ~clk;

  // Outputs packed as {max, mid, min, max_sel, mid_sel, min_sel}.
  assign obs = {max, mid, min, max_sel, mid_sel, min_sel};

  task automatic applyStimulus(input logic v, input logic [7:0] ia, input logic [7:0] ib,
                               input logic [7:0] ic);
    in_valid = v;
    a = ia;
    b = ib;
    c = ic;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    end
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_valid: got %b expected 0", out_valid);
    end
    compared++;
    if (obs !== RESET_VEC) begin
      mismatched++;
      $display("[TB] FAIL reset_values: got %h expected %h", obs, RESET_VEC);
    end
    applyStimulus(1'b1, 8'd15, 8'd7, 8'd8);
    rst_n = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      compared++;
      if (out_valid !== (k == LAT)) begin
        mismatched++;
        $display("[TB] FAIL release_latency_cycle%0d: got %b expected %b", k, out_valid, k == LAT);
      end
      if (k == LAT) begin
        compared++;
        if (obs !== {8'd15, 8'd8, 8'd7, 2'd0, 2'd2, 2'd1}) begin
          mismatched++;
          $display("[TB] FAIL release_first_set: got %h expected %h", obs,
                   {8'd15, 8'd8, 8'd7, 2'd0, 2'd2, 2'd1});
        end
      end
      if (k == 1) in_valid = 1'b0;
    end
  endtask

  task automatic test_directed();
    logic [7:0]  va[4] = '{8'd15, 8'd16, 8'd9, 8'd5};
    logic [7:0]  vb[4] = '{8'd7, 8'd21, 8'd9, 8'd200};
    logic [7:0]  vc[4] = '{8'd8, 8'd22, 8'd9, 8'd200};
    logic [29:0] ve[4] = '{
      {8'd15, 8'd8, 8'd7, 2'd0, 2'd2, 2'd1},
      {8'd22, 8'd21, 8'd16, 2'd2, 2'd1, 2'd0},
      {8'd9, 8'd9, 8'd9, 2'd0, 2'd1, 2'd2},
      {8'd200, 8'd200, 8'd5, 2'd1, 2'd2, 2'd0}
    };
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, va[i], vb[i], vc[i]);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (LAT - 1) @(negedge clk);
      compared++;
      if (out_valid !== 1'b1 || obs !== ve[i]) begin
        mismatched++;
        $display("[TB] FAIL directed%0d: got v=%b %h expected v=1 %h", i, out_valid, obs, ve[i]);
      end
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b0 || obs !== ve[i]) begin
        mismatched++;
        $display("[TB] FAIL directed%0d_hold: got v=%b %h expected v=0 %h", i, out_valid, obs, ve[i]);
      end
    end
  endtask

  task automatic test_extremes();
    logic [7:0] va[6] = '{8'd0, 8'd0, 8'd128, 8'd128, 8'd255, 8'd255};
    logic [7:0] vb[6] = '{8'd128, 8'd255, 8'd0, 8'd255, 8'd0, 8'd128};
    logic [7:0] vc[6] = '{8'd255, 8'd128, 8'd255, 8'd0, 8'd128, 8'd0};
    logic [5:0] vs[6] = '{
      {2'd2, 2'd1, 2'd0}, {2'd1, 2'd2, 2'd0}, {2'd2, 2'd0, 2'd1},
      {2'd1, 2'd0, 2'd2}, {2'd0, 2'd2, 2'd1}, {2'd0, 2'd1, 2'd2}
    };
    logic [29:0] exp;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, va[i], vb[i], vc[i]);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (LAT - 1) @(negedge clk);
      exp = {8'd255, 8'd128, 8'd0, vs[i]};
      compared++;
      if (out_valid !== 1'b1 || obs !== exp) begin
        mismatched++;
        $display("[TB] FAIL extreme%0d: got v=%b %h expected v=1 %h", i, out_valid, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  va[10] = '{8'd1, 8'd3, 8'd10, 8'd4, 8'd10, 8'd100, 8'd50, 8'd75, 8'd0, 8'd255};
    logic [7:0]  vb[10] = '{8'd2, 8'd2, 8'd10, 8'd10, 8'd4, 8'd50, 8'd100, 8'd50, 8'd0, 8'd255};
    logic [7:0]  vc[10] = '{8'd3, 8'd1, 8'd4, 8'd10, 8'd10, 8'd75, 8'd75, 8'd100, 8'd0, 8'd254};
    logic [29:0] ve[10] = '{
      {8'd3, 8'd2, 8'd1, 2'd2, 2'd1, 2'd0},
      {8'd3, 8'd2, 8'd1, 2'd0, 2'd1, 2'd2},
      {8'd10, 8'd10, 8'd4, 2'd0, 2'd1, 2'd2},
      {8'd10, 8'd10, 8'd4, 2'd1, 2'd2, 2'd0},
      {8'd10, 8'd10, 8'd4, 2'd0, 2'd2, 2'd1},
      {8'd100, 8'd75, 8'd50, 2'd0, 2'd2, 2'd1},
      {8'd100, 8'd75, 8'd50, 2'd1, 2'd2, 2'd0},
      {8'd100, 8'd75, 8'd50, 2'd2, 2'd0, 2'd1},
      {8'd0, 8'd0, 8'd0, 2'd0, 2'd1, 2'd2},
      {8'd255, 8'd255, 8'd254, 2'd0, 2'd1, 2'd2}
    };
    // Negedge t has seen t rising edges since set 0 was driven.
    for (int t = 0; t < 10 + LAT + 2; t++) begin
      @(negedge clk);
      if (t >= LAT && t < 10 + LAT) begin
        compared++;
        if (out_valid !== 1'b1 || obs !== ve[t - LAT]) begin
          mismatched++;
          $display("[TB] FAIL stream%0d: got v=%b %h expected v=1 %h", t - LAT, out_valid, obs,
                   ve[t - LAT]);
        end
      end else if (t >= 10 + LAT) begin
        compared++;
        if (out_valid !== 1'b0 || obs !== ve[9]) begin
          mismatched++;
          $display("[TB] FAIL stream_idle_hold: got v=%b %h expected v=0 %h", out_valid, obs, ve[9]);
        end
      end
      if (t < 10) applyStimulus(1'b1, va[t], vb[t], vc[t]);
      else in_valid = 1'b0;
    end
  endtask

  task automatic test_midstream_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 8'(40 + i), 8'(90 - i), 8'(60 + 3 * i));
    end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0 || obs !== RESET_VEC) begin
      mismatched++;
      $display("[TB] FAIL midreset_immediate: got v=%b %h expected v=0 %h", out_valid, obs, RESET_VEC);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b0 || obs !== RESET_VEC) begin
        mismatched++;
        $display("[TB] FAIL midreset_no_stale%0d: got v=%b %h expected v=0 %h", k, out_valid, obs,
                 RESET_VEC);
      end
    end
  endtask

  initial begin
    $display("[TB] starting cs bench, latency %0d", LAT);
    test_reset();
    test_directed();
    test_extremes();
    test_back_to_back();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
